// File: rtl/dpg_adder_uncompute_pkg.sv
// Shared definitions for the bit-serial DPG adder uncompute block:
// FSM state encodings and the default operand width.
package dpg_adder_uncompute_pkg;

   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/dpg_inv_cell.sv
// Combinational inverse of one DPG gate used as a full-adder cell:
// (p, q, r, s) = (a, a^b, sum, cout) maps back to (a, b, ancilla c, carry-in d).
module dpg_inv_cell (
   input  logic p,
   input  logic q,
   input  logic r,
   input  logic s,
   output logic a,
   output logic b,
   output logic c,
   output logic d
);

   assign a = p;
   assign b = q ^ p;
   assign d = r ^ q;
   // c is 0 whenever s was the true carry-out of this cell.
   assign c = s ^ (q & d) ^ (a & b);

endmodule

// File: rtl/dpg_adder_uncompute.sv
// Bit-serial inverse of a WIDTH-bit DPG ripple adder: recovers A, B and Cin
// MSB first from (P, Q, R, cout) and flags ancillas that fail to return to 0.
module dpg_adder_uncompute
   import dpg_adder_uncompute_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] p_in,
   input  logic [WIDTH-1:0] q_in,
   input  logic [WIDTH-1:0] r_in,
   input  logic             cout_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   output logic             cin_out,
   output logic [WIDTH-1:0] err_mask,
   output logic             anc_err
);

   localparam int              IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] p_q, q_q, r_q;
   logic             carry_q;
   logic [IDX_W-1:0] idx;
   logic             accept;
   logic             last_bit;
   logic             cell_a, cell_b, cell_c, cell_d;

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign accept    = in_valid && in_ready;
   assign last_bit  = (idx == '0);
   assign anc_err   = |err_mask;

   dpg_inv_cell u_cell (
      .p (p_q[idx]),
      .q (q_q[idx]),
      .r (r_q[idx]),
      .s (carry_q),
      .a (cell_a),
      .b (cell_b),
      .c (cell_c),
      .d (cell_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         // NOTE: sequential state always uses <= so every register samples pre-edge values.
         state <= state_nxt;
      end
   end

   always_comb begin
      // NOTE: default first, so no path through the case leaves state_nxt unassigned (no latch).
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (accept)               state_nxt = ST_RUN;
         ST_RUN:  if (last_bit)             state_nxt = ST_DONE;
         ST_DONE: if (out_ready)            state_nxt = ST_IDLE;
         default:                           state_nxt = ST_IDLE;
      endcase
   end

   // Capture on accept, then walk idx down from the MSB one bit per cycle;
   // the carry register hands each cell's recovered carry-in to the next lower bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q      <= '0;
         q_q      <= '0;
         r_q      <= '0;
         carry_q  <= 1'b0;
         idx      <= '0;
         a_out    <= '0;
         b_out    <= '0;
         err_mask <= '0;
         cin_out  <= 1'b0;
      end else if (accept) begin
         p_q      <= p_in;
         q_q      <= q_in;
         r_q      <= r_in;
         carry_q  <= cout_in;
         idx      <= IDX_MSB;
         a_out    <= '0;
         b_out    <= '0;
         err_mask <= '0;
      end else if (state == ST_RUN) begin
         a_out[idx]    <= cell_a;
         b_out[idx]    <= cell_b;
         err_mask[idx] <= cell_c;
         carry_q       <= cell_d;
         idx           <= idx - IDX_W'(1);
         if (last_bit) cin_out <= cell_d;
      end
   end

endmodule

// File: tb/tb_dpg_adder_uncompute.sv
// Self-checking bench for dpg_adder_uncompute: directed cases, backpressure,
// mid-run reset and random vectors built by a behavioural forward adder.
module tb_dpg_adder_uncompute;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] p_in = '0, q_in = '0, r_in = '0;
   logic         cout_in = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] a_out, b_out, err_mask;
   logic         cin_out, anc_err;

   int n_checks = 0;
   int n_pass   = 0;

   dpg_adder_uncompute #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .p_in      (p_in),
      .q_in      (q_in),
      .r_in      (r_in),
      .cout_in   (cout_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a_out     (a_out),
      .b_out     (b_out),
      .cin_out   (cin_out),
      .err_mask  (err_mask),
      .anc_err   (anc_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   // Forward DPG ripple adder as plain arithmetic: P=A, Q=A^B, {cout,R}=A+B+cin.
   task automatic fwd_adder(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                            output logic [W-1:0] p, output logic [W-1:0] q,
                            output logic [W-1:0] r, output logic cout);
      logic [W:0] sum;
      sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      p    = a;
      q    = a ^ b;
      r    = sum[W-1:0];
      cout = sum[W];
   endtask

   // Present one word set; returns #1 after the accepting edge with inputs scrambled.
   task automatic start_op(input logic [W-1:0] p, input logic [W-1:0] q,
                           input logic [W-1:0] r, input logic c);
      @(negedge clk);
      check("in_ready_idle", in_ready, 1);
      p_in = p; q_in = q; r_in = r; cout_in = c; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      p_in = W'($urandom); q_in = W'($urandom); r_in = W'($urandom); cout_in = 1'($urandom);
   endtask

   task automatic do_case(input logic [W-1:0] p, input logic [W-1:0] q, input logic [W-1:0] r,
                          input logic c, input logic [W-1:0] ea, input logic [W-1:0] eb,
                          input logic ecin, input logic [W-1:0] eerr, input int bp);
      int lat;
      start_op(p, q, r, c);
      @(negedge clk);
      check("clear_on_accept", a_out, 0);
      check("busy_not_ready", in_ready, 0);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      check("latency", lat, W + 1);
      check("a_out", a_out, ea);
      check("b_out", b_out, eb);
      check("cin_out", cin_out, ecin);
      check("err_mask", err_mask, eerr);
      check("anc_err", anc_err, |eerr);
      // Hold off the consumer while hammering in_valid with other data.
      for (int i = 0; i < bp; i++) begin
         in_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         check("bp_valid", out_valid, 1);
         check("bp_ready", in_ready, 0);
         check("bp_a", a_out, ea);
         check("bp_b", b_out, eb);
         check("bp_err", err_mask, eerr);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("idle_after_handshake", in_ready, 1);
      check("valid_dropped", out_valid, 0);
      check("a_kept_in_idle", a_out, ea);
   endtask

   initial begin
      logic [W-1:0] ra, rb, rp, rq, rr;
      logic         rc, rco;

      #3;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_a", a_out, 0);
      check("rst_b", b_out, 0);
      check("rst_err", err_mask, 0);
      check("rst_cin", cin_out, 0);
      check("rst_anc", anc_err, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases.
      do_case(16'h1234, 16'h1D3B, 16'h2143, 1'b0, 16'h1234, 16'h0F0F, 1'b0, 16'h0000, 0);
      do_case(16'hFFFF, 16'hFFFE, 16'h0001, 1'b1, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 0);
      do_case(16'h1234, 16'h1D3B, 16'h2143, 1'b1, 16'h1234, 16'h0F0F, 1'b0, 16'h8000, 0);
      do_case(16'h1234, 16'h1D3B, 16'h2143, 1'b0, 16'h1234, 16'h0F0F, 1'b0, 16'h0000, 10);

      // Reset in the middle of RUN cycle 8.
      start_op(16'h1234, 16'h1D3B, 16'h2143, 1'b0);
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_ready", in_ready, 1);
      check("mid_rst_a", a_out, 0);
      check("mid_rst_b", b_out, 0);
      check("mid_rst_err", err_mask, 0);
      check("mid_rst_cin", cin_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_case(16'hFFFF, 16'hFFFE, 16'h0001, 1'b1, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 0);

      // Random round trips through the behavioural forward adder.
      for (int v = 0; v < 1000; v++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         fwd_adder(ra, rb, rc, rp, rq, rr, rco);
         do_case(rp, rq, rr, rco, ra, rb, rc, '0, int'($urandom_range(0, 2)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
